// File: rtl/quad_poly_pkg.sv
// Shared types and sizing helpers for the quadratic polynomial evaluator.
// FSM encoding, accumulator width and coefficient address map.
package quad_poly_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQ,
    S_MAC,
    S_DONE
  } state_t;

  localparam int A_OFS = 0;
  localparam int B_OFS = 1;

  function automatic int acc_w(
    int nch,
    int xw,
    int cw
  );
    return cw + 2*xw + 2 + $clog2(nch + 1);
  endfunction

  function automatic int g_addr(int nch);
    return 2*nch;
  endfunction

endpackage

// File: rtl/quad_poly_eval_if.sv
// Start/busy/done handshake, inputs, result and coefficient port.
// master drives requests, slave is the evaluator.
interface quad_poly_eval_if #(
  parameter int NCH = 3,
  parameter int XW  = 4,
  parameter int CW  = 5,
  parameter int OW  = 19
);

  logic                  start;
  logic [NCH*XW-1:0]     x_in;
  logic                  cfg_we;
  logic [3:0]            cfg_addr;
  logic signed [CW-1:0]  cfg_data;
  logic                  busy;
  logic                  done;
  logic signed [OW-1:0]  out;
  logic                  ovf;

  modport master (
    output start,
    output x_in,
    output cfg_we,
    output cfg_addr,
    output cfg_data,
    input  busy,
    input  done,
    input  out,
    input  ovf
  );

  modport slave (
    input  start,
    input  x_in,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_data,
    output busy,
    output done,
    output out,
    output ovf
  );

endinterface

// File: rtl/quad_poly_cfg.sv
// Coefficient register file: a_i, b_i and g, write-gated on busy.
// a/b are snapshotted at start so a same-cycle write cannot leak in.
module quad_poly_cfg
  import quad_poly_pkg::*;
#(
  parameter int NCH = 3,
  parameter int CW  = 5,
  parameter int CHW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [3:0]           i_addr,
  input  logic signed [CW-1:0] i_data,
  input  logic                 i_busy,
  input  logic                 i_load,
  input  logic [CHW-1:0]       i_ch,
  output logic signed [CW-1:0] o_a,
  output logic signed [CW-1:0] o_b,
  output logic signed [CW-1:0] o_g
);

  logic signed [CW-1:0] r_a  [NCH];
  logic signed [CW-1:0] r_b  [NCH];
  logic signed [CW-1:0] r_la [NCH];
  logic signed [CW-1:0] r_lb [NCH];
  logic signed [CW-1:0] r_g;

  logic w_wr;
  assign w_wr = i_we && !i_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_a[i]  <= '0;
        r_b[i]  <= '0;
        r_la[i] <= '0;
        r_lb[i] <= '0;
      end
      r_g <= '0;
    end else begin
      if (i_load) begin
        for (int i = 0; i < NCH; i++) begin
          r_la[i] <= r_a[i];
          r_lb[i] <= r_b[i];
        end
      end
      if (w_wr) begin
        for (int i = 0; i < NCH; i++) begin
          if ({1'b0, i_addr} == 5'(2*i + A_OFS))
            r_a[i] <= i_data;
          if ({1'b0, i_addr} == 5'(2*i + B_OFS))
            r_b[i] <= i_data;
        end
        if ({1'b0, i_addr} == 5'(g_addr(NCH)))
          r_g <= i_data;
      end
    end
  end

  always_comb begin
    o_a = '0;
    o_b = '0;
    for (int i = 0; i < NCH; i++) begin
      if (i_ch == CHW'(i)) begin
        o_a = r_la[i];
        o_b = r_lb[i];
      end
    end
  end

  // g is consumed on the accept edge, so the live register is already the old value
  assign o_g = r_g;

endmodule

// File: rtl/quad_poly_eval.sv
// Sequential evaluator of g + sum(a_i*x_i^2 + b_i*x_i) over NCH channels.
// One squarer and one MAC, saturating signed output.
module quad_poly_eval
  import quad_poly_pkg::*;
#(
  parameter int NCH = 3,
  parameter int XW  = 4,
  parameter int CW  = 5,
  parameter int OW  = 19
) (
  input  logic             clk,
  input  logic             rst,
  quad_poly_eval_if.slave  bus
);

  localparam int ACCW = acc_w(NCH, XW, CW);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PAW  = CW + 2*XW + 1;
  localparam int PBW  = CW + XW + 1;
  localparam int SW   = ((ACCW > OW) ? ACCW : OW) + 1;

  localparam logic signed [SW-1:0] SMAX =
    {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = ~SMAX;

  state_t                 r_state;
  logic [XW-1:0]          r_x [NCH];
  logic [CHW-1:0]         r_ch;
  logic [2*XW-1:0]        r_sq;
  logic signed [ACCW-1:0] r_acc;
  logic signed [OW-1:0]   r_out;
  logic                   r_ovf;
  logic                   r_done;
  logic                   r_busy;

  logic                   w_start;
  logic [XW-1:0]          w_xc;
  logic [2*XW-1:0]        w_sq;
  logic signed [CW-1:0]   w_a;
  logic signed [CW-1:0]   w_b;
  logic signed [CW-1:0]   w_g;
  logic signed [PAW-1:0]  w_pa;
  logic signed [PBW-1:0]  w_pb;
  logic signed [ACCW-1:0] w_acc_nx;
  logic signed [SW-1:0]   w_ext;
  logic                   w_hi;
  logic                   w_lo;
  logic signed [OW-1:0]   w_sat;

  assign w_start = (r_state == S_IDLE) && bus.start;

  quad_poly_cfg #(
    .NCH (NCH),
    .CW  (CW),
    .CHW (CHW)
  ) u_cfg (
    .clk    (clk),
    .rst    (rst),
    .i_we   (bus.cfg_we),
    .i_addr (bus.cfg_addr),
    .i_data (bus.cfg_data),
    .i_busy (r_busy),
    .i_load (w_start),
    .i_ch   (r_ch),
    .o_a    (w_a),
    .o_b    (w_b),
    .o_g    (w_g)
  );

  always_comb begin
    w_xc = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_ch == CHW'(i))
        w_xc = r_x[i];
    end
  end

  assign w_sq = (2*XW)'(w_xc) * (2*XW)'(w_xc);

  // x and sq are unsigned: prefix a zero before the signed multiply
  assign w_pa = PAW'(w_a) * PAW'($signed({1'b0, r_sq}));
  assign w_pb = PBW'(w_b) * PBW'($signed({1'b0, w_xc}));

  assign w_acc_nx = r_acc + ACCW'(w_pa) + ACCW'(w_pb);

  assign w_ext = SW'(r_acc);
  assign w_hi  = w_ext > SMAX;
  assign w_lo  = w_ext < SMIN;
  assign w_sat = w_hi ? SMAX[OW-1:0] :
                 w_lo ? SMIN[OW-1:0] :
                        w_ext[OW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      for (int i = 0; i < NCH; i++)
        r_x[i] <= '0;
      r_ch   <= '0;
      r_sq   <= '0;
      r_acc  <= '0;
      r_out  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            for (int i = 0; i < NCH; i++)
              r_x[i] <= bus.x_in[i*XW +: XW];
            r_acc   <= ACCW'(w_g);
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SQ;
          end
        end
        S_SQ: begin
          r_sq    <= w_sq;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= w_acc_nx;
          if (r_ch == CHW'(NCH-1)) begin
            r_state <= S_DONE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= S_SQ;
          end
        end
        S_DONE: begin
          r_out   <= w_sat;
          r_ovf   <= w_hi | w_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.out  = r_out;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_quad_poly_eval.sv
// Bench for quad_poly_eval: OW=19 and OW=12 instances against a
// countdown/arithmetic reference model, plus directed literal cases.
module tb_quad_poly_eval;

  localparam int NC = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [2];
  logic        st    [2];
  logic        we    [2];
  logic [3:0]  addr  [2];
  logic [4:0]  data  [2];
  logic [11:0] xin   [2];

  quad_poly_eval_if #(.OW(19)) if0 ();
  quad_poly_eval_if #(.OW(12)) if1 ();

  assign if0.start    = st[0];
  assign if0.x_in     = xin[0];
  assign if0.cfg_we   = we[0];
  assign if0.cfg_addr = addr[0];
  assign if0.cfg_data = data[0];
  assign if1.start    = st[1];
  assign if1.x_in     = xin[1];
  assign if1.cfg_we   = we[1];
  assign if1.cfg_addr = addr[1];
  assign if1.cfg_data = data[1];

  quad_poly_eval #(.OW(19)) u0 (
    .clk (clk),
    .rst (rst_v[0]),
    .bus (if0)
  );

  quad_poly_eval #(.OW(12)) u1 (
    .clk (clk),
    .rst (rst_v[1]),
    .bus (if1)
  );

  int   d_out  [2];
  logic d_busy [2];
  logic d_done [2];
  logic d_ovf  [2];

  always_comb begin
    d_out[0]  = int'(if0.out);
    d_out[1]  = int'(if1.out);
    d_busy[0] = if0.busy;
    d_busy[1] = if1.busy;
    d_done[0] = if0.done;
    d_done[1] = if1.done;
    d_ovf[0]  = if0.ovf;
    d_ovf[1]  = if1.ovf;
  end

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int k, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0d, want %0d", nm, k, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt  [2];
  int m_res  [2];
  int m_out  [2];
  bit m_busy [2];
  bit m_done [2];
  bit m_ovf  [2];
  int m_coef [2][NC];

  function automatic int owf(int k);
    return (k == 0) ? 19 : 12;
  endfunction

  function automatic int sat(int v, int ow);
    int hi = (1 << (ow-1)) - 1;
    int lo = -(1 << (ow-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int evalf(int k, logic [11:0] xv);
    int r = m_coef[k][6];
    for (int i = 0; i < 3; i++) begin
      int xi = int'(xv[i*4 +: 4]);
      r += m_coef[k][2*i]*xi*xi + m_coef[k][2*i+1]*xi;
    end
    return r;
  endfunction

  task automatic mstep(int k, bit r, bit s, bit w, int a, int d,
                       logic [11:0] xv);
    bit was_busy;
    if (r) begin
      m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      m_out[k] = 0; m_ovf[k] = 0;
      for (int i = 0; i < NC; i++) m_coef[k][i] = 0;
    end else begin
      was_busy  = m_cnt[k] > 0;
      m_done[k] = 0;
      if (m_cnt[k] > 0) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin
          m_done[k] = 1;
          m_busy[k] = 0;
          m_out[k]  = sat(m_res[k], owf(k));
          m_ovf[k]  = (m_out[k] != m_res[k]);
        end
      end else if (s) begin
        m_res[k]  = evalf(k, xv);
        m_cnt[k]  = 7;
        m_busy[k] = 1;
      end
      if (w && !was_busy && a < NC) m_coef[k][a] = d;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      mstep(k, rst_v[k], st[k], we[k], int'(addr[k]),
            int'($signed(data[k])), xin[k]);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, int'(d_busy[k]), int'(m_busy[k]));
        chk("done", k, int'(d_done[k]), int'(m_done[k]));
        chk("out",  k, d_out[k], m_out[k]);
        chk("ovf",  k, int'(d_ovf[k]), int'(m_ovf[k]));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wr(int k, int a, int d);
    we[k] = 1'b1; addr[k] = 4'(a); data[k] = 5'(d);
    @(negedge clk);
    we[k] = 1'b0;
  endtask

  task automatic start_pulse(int k, logic [11:0] xv);
    xin[k] = xv; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
  endtask

  task automatic wait_done(int k, int eo, int eov, output int n);
    bit got = 1'b0;
    n = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      got = d_done[k];
    end
    chk("done_seen", k, int'(got), 1);
    chk("lit_out", k, d_out[k], eo);
    chk("lit_ovf", k, int'(d_ovf[k]), eov);
    chk("model_lit", k, m_out[k], eo);
  endtask

  task automatic run(int k, int x0, int x1, int x2, int eo, int eov);
    int n;
    start_pulse(k, {4'(x2), 4'(x1), 4'(x0)});
    wait_done(k, eo, eov, n);
    chk("latency", k, n, 7);
    @(negedge clk);
  endtask

  int cf [NC] = '{5, 8, -4, 3, 6, -2, 13};

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; st[k] = 1'b0; we[k] = 1'b0;
      addr[k] = '0; data[k] = '0; xin[k] = '0;
    end
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    @(negedge clk);
    chk("rst_out", 0, d_out[0], 0);
    chk("rst_busy", 0, int'(d_busy[0]), 0);
    chk("rst_ovf", 1, int'(d_ovf[1]), 0);

    for (int i = 0; i < NC; i++) wr(0, i, cf[i]);
    run(0, 0, 0, 0, 13, 0);
    run(0, 2, 0, 0, 49, 0);
    run(0, 1, 1, 1, 29, 0);
    run(0, 15, 15, 15, 1723, 0);

    // second start during a run must be dropped
    start_pulse(0, 12'h111);
    @(negedge clk);
    start_pulse(0, 12'hfff);
    wait_done(0, 29, 0, n);
    repeat (12) @(negedge clk);

    // g write while busy is ignored
    start_pulse(0, 12'h000);
    @(negedge clk);
    wr(0, 6, 0);
    wait_done(0, 13, 0, n);
    @(negedge clk);
    run(0, 0, 0, 0, 13, 0);
    wr(0, 6, 0);
    run(0, 0, 0, 0, 0, 0);

    // write in the start cycle lands, but this run sees the old g
    we[0] = 1'b1; addr[0] = 4'd6; data[0] = 5'd7;
    start_pulse(0, 12'h000);
    we[0] = 1'b0;
    wait_done(0, 0, 0, n);
    @(negedge clk);
    run(0, 0, 0, 0, 7, 0);

    // reset mid-evaluation
    start_pulse(0, 12'h111);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("abort_busy", 0, int'(d_busy[0]), 0);
    chk("abort_out", 0, d_out[0], 0);
    repeat (12) @(negedge clk);
    run(0, 15, 15, 15, 0, 0);

    for (int i = 0; i < NC; i++) wr(1, i, 15);
    run(1, 15, 15, 15, 2047, 1);
    run(1, 0, 0, 0, 15, 0);
    for (int i = 0; i < NC; i++) wr(1, i, -16);
    run(1, 15, 15, 15, -2048, 1);

    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 2; k++) begin
        st[k]    = ($urandom_range(0, 9) == 0);
        we[k]    = ($urandom_range(0, 3) == 0);
        addr[k]  = 4'($urandom_range(0, 15));
        data[k]  = 5'($urandom);
        xin[k]   = 12'($urandom);
        rst_v[k] = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; we[k] = 1'b0; rst_v[k] = 1'b0;
    end
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
